// File: rtl/instr_encoder.sv
// Three-phase instruction encoder: captures R/I/J fields, forms a 32-bit word, writes it to imem.
// Define ENCODER_CHECK_EN to reject illegal format/opcode pairs and raise a sticky err flag.
module instr_encoder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_addr,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] Capacity = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StEncode, StWrite} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                wren_q, wren_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                capture;

  logic [1:0]  fmt_q;
  logic [5:0]  op_q, funct_q;
  logic [4:0]  rs_q, rt_q, rd_q, shamt_q;
  logic [15:0] imm_q;
  logic [25:0] jaddr_q;
  logic [31:0] word;
  logic        illegal;

  // Format 11 shares the I-type layout; it only matters when the legality check is off.
  always_comb begin
    word = {op_q, rs_q, rt_q, imm_q};
    unique case (fmt_q)
      2'b00:   word = {6'b000000, rs_q, rt_q, rd_q, shamt_q, funct_q};
      2'b10:   word = {op_q, jaddr_q};
      default: word = {op_q, rs_q, rt_q, imm_q};
    endcase
  end

`ifdef ENCODER_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    illegal = 1'b0;
    unique case (fmt_q)
      2'b00:   illegal = (op_q != 6'h00);
      2'b01:   illegal = (op_q == 6'h00) || (op_q == 6'h02) || (op_q == 6'h03);
      2'b10:   illegal = !((op_q == 6'h02) || (op_q == 6'h03));
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (state_q == StEncode && illegal) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  assign full     = (count_q == Capacity);
  assign in_ready = (state_q == StIdle) && !full && !load_base;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wren_d  = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        // load_base has priority over a simultaneous in_valid
        if (load_base) begin
          ptr_d   = base_addr;
          count_d = '0;
        end else if (in_valid && !full) begin
          capture = 1'b1;
          state_d = StEncode;
        end
      end
      StEncode: begin
        if (illegal) begin
          state_d = StIdle;
        end else begin
          wren_d  = 1'b1;
          data_d  = word;
          addr_d  = ptr_q;
          state_d = StWrite;
        end
      end
      StWrite: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (count_q != Capacity) count_d = count_q + (ADDR_W + 1)'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
      wren_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      wren_q  <= wren_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_q   <= '0;
      op_q    <= '0;
      funct_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
      imm_q   <= '0;
      jaddr_q <= '0;
    end else if (capture) begin
      fmt_q   <= in_fmt;
      op_q    <= in_op;
      funct_q <= in_funct;
      rs_q    <= in_rs;
      rt_q    <= in_rt;
      rd_q    <= in_rd;
      shamt_q <= in_shamt;
      imm_q   <= in_imm;
      jaddr_q <= in_addr;
    end
  end

  assign imem_wren = wren_q;
  assign imem_data = data_q;
  assign imem_addr = addr_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against an event-scheduled reference model.
module tb_instr_encoder;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, load_base;
  logic [1:0]    in_fmt;
  logic [5:0]    in_op, in_funct;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_addr;
  logic [AW-1:0] base_addr;
  logic          imem_wren, full, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_op(in_op), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_addr(in_addr), .load_base(load_base),
    .base_addr(base_addr), .imem_wren(imem_wren), .imem_addr(imem_addr),
    .imem_data(imem_data), .count(count), .full(full), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one pending instruction scheduled by edge number.
  int          edge_n = 0;
  int          m_ptr, m_count, m_addr;
  bit          m_wren, m_err;
  logic [31:0] m_data;
  bit          p_valid = 0;
  bit          p_legal;
  int          p_edge, p_addr;
  logic [31:0] p_data;
  bit          ready_known = 0;
  int          waddr[$];
  logic [31:0] wdata[$];

  function automatic logic [31:0] ref_word();
    longint w;
    case (in_fmt)
      2'd0:    w = in_rs * 2**21 + in_rt * 2**16 + in_rd * 2**11 + in_shamt * 64 + in_funct;
      2'd2:    w = longint'(in_op) * 2**26 + in_addr;
      default: w = longint'(in_op) * 2**26 + in_rs * 2**21 + in_rt * 2**16 + in_imm;
    endcase
    return w[31:0];
  endfunction

  function automatic bit ref_legal();
`ifdef ENCODER_CHECK_EN
    case (in_fmt)
      2'd0:    return in_op == 0;
      2'd1:    return !(in_op == 0 || in_op == 2 || in_op == 3);
      2'd2:    return in_op == 2 || in_op == 3;
      default: return 0;
    endcase
`else
    return 1;
`endif
  endfunction

  function automatic bit model_ready();
    return !p_valid && (m_count < CAP) && !load_base;
  endfunction

  task automatic tick();
    bit r_pre, idle_pre;
    #1;
    r_pre    = model_ready();
    idle_pre = !p_valid;
    if (ready_known) check("in_ready", in_ready, r_pre);
    @(posedge clk);
    edge_n++;
    if (rst) begin
      p_valid = 0; m_ptr = 0; m_count = 0; m_wren = 0; m_data = 0; m_addr = 0; m_err = 0;
    end else begin
      m_wren = 0;
      if (p_valid && edge_n == p_edge + 1) begin
        if (p_legal) begin
          m_wren = 1; m_data = p_data; m_addr = p_addr;
        end else begin
          m_err = 1; p_valid = 0;
        end
      end else if (p_valid && edge_n == p_edge + 2) begin
        m_ptr = (m_ptr + 1) % CAP;
        if (m_count < CAP) m_count++;
        p_valid = 0;
      end
      if (idle_pre && load_base) begin
        m_ptr = int'(base_addr); m_count = 0;
      end else if (r_pre && in_valid) begin
        p_valid = 1; p_edge = edge_n; p_addr = m_ptr;
        p_data = ref_word(); p_legal = ref_legal();
      end
    end
    #1;
    check("imem_wren", imem_wren, m_wren);
    check("imem_data", imem_data, m_data);
    check("imem_addr", imem_addr, m_addr);
    check("count", count, m_count);
    check("full", full, m_count == CAP);
    check("err", err, m_err);
    if (imem_wren) begin
      waddr.push_back(int'(imem_addr));
      wdata.push_back(imem_data);
    end
    if (rst) ready_known = 1;
  endtask

  task automatic set_fields(logic [1:0] f, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                            logic [4:0] rd, logic [4:0] sh, logic [5:0] fn, logic [15:0] imm,
                            logic [25:0] ja);
    in_fmt = f; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_addr = ja;
  endtask

  task automatic rand_fields(bit legal_only);
    in_fmt   = legal_only ? 2'($urandom_range(0, 2)) : 2'($urandom);
    in_op    = 6'($urandom);
    in_rs    = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
    in_shamt = 5'($urandom); in_funct = 6'($urandom);
    in_imm   = 16'($urandom); in_addr = 26'($urandom);
    if (legal_only) begin
      case (in_fmt)
        2'd0:    in_op = 6'd0;
        2'd1:    in_op = 6'($urandom_range(4, 63));
        default: in_op = 6'($urandom_range(2, 3));
      endcase
    end
  endtask

  // Holds in_valid until the model says the word was taken (bounded).
  task automatic send();
    bit acc;
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      acc = model_ready();
      tick();
      if (acc) break;
    end
    in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; load_base = 0;
    tick(); tick();
    rst = 0;
    waddr.delete(); wdata.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    base_addr = '0;
    set_fields(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    do_reset();

    // ADDU $3,$1,$2
    set_fields(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
    send();
    tick();
    check("addu_wren", imem_wren, 1);
    check("addu_data", imem_data, 32'h00221821);
    check("addu_addr", imem_addr, 0);
    tick();
    check("addu_count", count, 1);

    // ADDIU then BEQ back-to-back
    do_reset();
    set_fields(2'd1, 6'h09, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    send();
    set_fields(2'd1, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    send();
    repeat (3) tick();
    check("pair_n", waddr.size(), 2);
    if (waddr.size() == 2) begin
      check("addiu_data", wdata[0], 32'h24020005);
      check("addiu_addr", waddr[0], 0);
      check("beq_data", wdata[1], 32'h1022FFFF);
      check("beq_addr", waddr[1], 1);
    end

    // Jump after load_base near the top of memory: wraps
    do_reset();
    load_base = 1; base_addr = 10'h3FE; in_valid = 1;
    tick();
    load_base = 0; in_valid = 0;
    set_fields(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h100000);
    send(); send(); send();
    repeat (3) tick();
    check("jump_n", waddr.size(), 3);
    if (waddr.size() == 3) begin
      check("jump_data", wdata[0], 32'h08100000);
      check("jump_addr0", waddr[0], 10'h3FE);
      check("jump_addr1", waddr[1], 10'h3FF);
      check("jump_addr2", waddr[2], 10'h000);
    end

    // Format 11 handling
    do_reset();
    set_fields(2'd3, 6'h09, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
    send();
    repeat (3) tick();
`ifdef ENCODER_CHECK_EN
    check("fmt3_err", err, 1);
    check("fmt3_nowrite", waddr.size(), 0);
`else
    check("fmt3_err", err, 0);
    check("fmt3_data", (wdata.size() == 1) ? wdata[0] : 32'hDEADBEEF, 32'h24221234);
`endif
    set_fields(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
    send();
    repeat (3) tick();
`ifdef ENCODER_CHECK_EN
    check("after_err_addr", (waddr.size() == 1) ? waddr[0] : -1, 0);
    check("err_sticky", err, 1);
`else
    check("after_fmt3_addr", (waddr.size() == 2) ? waddr[1] : -1, 1);
`endif

    // Reset the cycle after an accept abandons the word
    do_reset();
    send();
    rst = 1;
    tick();
    rst = 0;
    check("rst_wren", imem_wren, 0);
    check("rst_data", imem_data, 0);
    check("rst_count", count, 0);
    repeat (3) tick();
    check("rst_nowrite", waddr.size(), 0);

    // Fill to capacity
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      rand_fields(1);
      send();
    end
    repeat (3) tick();
    check("full_flag", full, 1);
    check("full_count", count, CAP);
    in_valid = 1;
    repeat (5) tick();
    in_valid = 0;
    check("full_writes", waddr.size(), CAP);
    load_base = 1; base_addr = '0;
    tick();
    load_base = 0;
    check("full_cleared", full, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_fields($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom);
      load_base = ($urandom_range(0, 15) == 0);
      base_addr = AW'($urandom);
      rst       = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0; in_valid = 0; load_base = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  instruction fields present.
REQ-005 in_ready  output  1  encoder accepts fields this cycle.
REQ-006 in_fmt  input  2  format: 00 R, 01 I, 10 J, 11 illegal.
REQ-007 in_op / in_funct  input  6 / 6  opcode / function fields.
REQ-008 in_rs / in_rt / in_rd / in_shamt  input  5 each  register and shift fields.
REQ-009 in_imm  input  16  immediate; in_addr  input  26  jump target.
REQ-010 load_base  input  1  load write pointer from base_addr; base_addr  input  ADDR_W.
REQ-011 imem_wren  output  1  one-cycle write strobe to instruction memory.
REQ-012 imem_addr  output  ADDR_W  write address; imem_data  output  32  encoded word.
REQ-013 count  output  ADDR_W+1  words written since reset or last load_base.
REQ-014 full  output  1  count == 2^ADDR_W.
REQ-015 err  output  1  sticky illegal-instruction flag (see Configuration).

Function
REQ-016 FSM states IDLE, ENCODE, WRITE; reset state IDLE.
REQ-017 in_ready = 1 only in IDLE with full = 0 and load_base = 0.
REQ-018 Handshake: in_valid & in_ready at edge N captures all fields; IDLE -> ENCODE.
REQ-019 ENCODE (cycle N+1): registered 32-bit word formed; ENCODE -> WRITE.
REQ-020 WRITE (cycle N+2): imem_wren = 1 for exactly one cycle with imem_data and imem_addr = write pointer; pointer += 1, count += 1; WRITE -> IDLE.
REQ-021 Throughput: one word per 3 cycles; in_ready low in ENCODE and WRITE; in_valid ignored there.
REQ-022 R encoding: {6'b000000, rs, rt, rd, shamt, funct}; in_op ignored.
REQ-023 I encoding: {op, rs, rt, imm}.
REQ-024 J encoding: {op, addr}.
REQ-025 Write pointer wraps modulo 2^ADDR_W; count saturates at 2^ADDR_W; full blocks acceptance.
REQ-026 load_base in IDLE: pointer <= base_addr, count <= 0 next edge; ignored in ENCODE/WRITE.
REQ-027 load_base and in_valid same cycle: load_base wins, no capture.
REQ-028 imem_data and imem_addr hold last values when imem_wren = 0.

Reset
REQ-029 rst at any edge: state IDLE, pointer 0, count 0, imem_wren 0, imem_data 0, imem_addr 0, err 0.
REQ-030 rst in ENCODE or WRITE abandons the instruction; no write issued.
REQ-031 rst dominates load_base and in_valid.

Configuration
REQ-032 Macro ENCODER_CHECK_EN defined: in ENCODE, illegal = fmt 11, or R with op != 00, or J with op not 02/03, or I with op in {00,02,03}; illegal word sets err (sticky until rst), skips WRITE (ENCODE -> IDLE), pointer/count unchanged.
REQ-033 Macro undefined: no check; fmt 11 encoded as I-type; err tied 0.

Verification
REQ-034 ADDU $3,$1,$2 (fmt 00, rs 1, rt 2, rd 3, shamt 0, funct 21h) accepted at N -> imem_wren at N+2, imem_data 00221821h, imem_addr 0, count 1.
REQ-035 ADDIU $2,$0,5 (fmt 01, op 09h, rt 2, imm 0005h) then BEQ $1,$2,-1 (op 04h, imm FFFFh) back-to-back -> 24020005h at addr 0, 1022FFFFh at addr 1; in_ready low 2 cycles after each accept.
REQ-036 J 100000h (fmt 10, op 02h) after load_base with base_addr 3FEh -> 08100000h at 3FEh; next word at 3FFh, following at 000h (wrap).
REQ-037 ADDR_W=2, four words written -> full = 1, count 4, in_ready 0; fifth in_valid produces no write; load_base clears full.
REQ-038 With ENCODER_CHECK_EN: fmt 11 word -> no imem_wren, err = 1 and stays 1; subsequent legal word writes at unchanged address; without macro: same stimulus written as I-type, err 0.
REQ-039 rst asserted the cycle after an accept -> no imem_wren, all outputs at reset values next cycle.
